// File: rtl/cva6v_retire_trace_buffer.sv
// Retire-trace capture: packs up to NR_PORTS commit records per cycle into a FIFO and streams them out.
// Define CVA6V_RETIRE_TRACE_TS_EN to add a per-entry 32-bit cycle timestamp on trace_ts_o.
module cva6v_retire_trace_buffer #(
   parameter int unsigned NR_PORTS = 2,
   parameter int unsigned XLEN     = 64,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned CNT_W    = 48
) (
   input  logic                                           clk_i,
   input  logic                                           rst_i,
   input  logic                                           enable_i,
   input  logic                                           flush_i,
   input  logic                                           eot_i,
   input  logic [NR_PORTS-1:0]                            commit_valid_i,
   input  logic [NR_PORTS*XLEN-1:0]                       commit_pc_i,
   input  logic [NR_PORTS*32-1:0]                         commit_insn_i,
   input  logic [NR_PORTS-1:0]                            commit_trap_i,
   output logic                                           trace_valid_o,
   input  logic                                           trace_ready_i,
   output logic [((NR_PORTS > 1) ? $clog2(NR_PORTS) : 1)-1:0] trace_port_o,
   output logic [XLEN-1:0]                                trace_pc_o,
`ifdef CVA6V_RETIRE_TRACE_TS_EN
   output logic [31:0]                                    trace_ts_o,
`endif
   output logic [31:0]                                    trace_insn_o,
   output logic                                           trace_trap_o,
   output logic [$clog2(DEPTH):0]                         level_o,
   output logic [CNT_W-1:0]                               retired_cnt_o,
   output logic [15:0]                                    drop_cnt_o,
   output logic                                           overflow_o,
   output logic                                           done_o
);

   localparam int unsigned PORT_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]        state_q;
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [LVL_W-1:0]  level_q, level_nxt, k, free;
   logic [PTR_W-1:0]  offs [NR_PORTS];
   logic [CNT_W-1:0]  retired_q;
   logic [15:0]       drop_q;
   logic              ovf_q;
   logic              capture, fits, push, pop, drop;
   logic [CNT_W:0]    ret_sum;
   logic [16:0]       drop_sum;

   logic [XLEN-1:0]   pc_mem   [DEPTH];
   logic [31:0]       insn_mem [DEPTH];
   logic              trap_mem [DEPTH];
   logic [PORT_W-1:0] port_mem [DEPTH];

   always_comb begin
      capture = enable_i && (state_q == ST_RUN) && !flush_i;
      // offs[p] is the slot of port p among this cycle's valid ports, so writes pack densely in port order
      k = '0;
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
         offs[p] = k[PTR_W-1:0];
         if (capture && commit_valid_i[p]) k = k + LVL_W'(1);
      end
      free      = LVL_W'(DEPTH) - level_q;
      fits      = (free >= k);
      push      = capture && fits;
      drop      = capture && !fits;
      pop       = (level_q != '0) && trace_ready_i;
      level_nxt = level_q + (push ? k : '0) - LVL_W'(pop);
      ret_sum   = {1'b0, retired_q} + (CNT_W+1)'(k);
      drop_sum  = {1'b0, drop_q} + 17'(k);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_RUN;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         level_q   <= '0;
         retired_q <= '0;
         drop_q    <= '0;
         ovf_q     <= 1'b0;
      end else if (flush_i) begin
         state_q  <= ST_RUN;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         level_q <= level_nxt;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push) wr_ptr_q <= wr_ptr_q + k[PTR_W-1:0];
         if (capture) retired_q <= ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
         if (drop) begin
            drop_q <= drop_sum[16] ? '1 : drop_sum[15:0];
            ovf_q  <= 1'b1;
         end
         case (state_q)
            ST_RUN:   if (eot_i) state_q <= ST_DRAIN;
            ST_DRAIN: if (level_nxt == '0) state_q <= ST_DONE;
            default:  state_q <= state_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
         if (push && commit_valid_i[p]) begin
            pc_mem[wr_ptr_q + offs[p]]   <= commit_pc_i[p*XLEN +: XLEN];
            insn_mem[wr_ptr_q + offs[p]] <= commit_insn_i[p*32 +: 32];
            trap_mem[wr_ptr_q + offs[p]] <= commit_trap_i[p];
            port_mem[wr_ptr_q + offs[p]] <= PORT_W'(p);
         end
      end
   end

`ifdef CVA6V_RETIRE_TRACE_TS_EN
   logic [31:0] ts_q;
   logic [31:0] ts_mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) ts_q <= '0;
      else       ts_q <= ts_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
         if (push && commit_valid_i[p]) ts_mem[wr_ptr_q + offs[p]] <= ts_q;
      end
   end

   assign trace_ts_o = trace_valid_o ? ts_mem[rd_ptr_q] : '0;
`endif

   assign trace_valid_o = (level_q != '0);
   assign trace_port_o  = trace_valid_o ? port_mem[rd_ptr_q] : '0;
   assign trace_pc_o    = trace_valid_o ? pc_mem[rd_ptr_q]   : '0;
   assign trace_insn_o  = trace_valid_o ? insn_mem[rd_ptr_q] : '0;
   assign trace_trap_o  = trace_valid_o ? trap_mem[rd_ptr_q] : 1'b0;
   assign level_o       = level_q;
   assign retired_cnt_o = retired_q;
   assign drop_cnt_o    = drop_q;
   assign overflow_o    = ovf_q;
   assign done_o        = (state_q == ST_DONE);

endmodule
